// File: rtl/ysyx_23060221_axi_sram_slave.sv
// AXI4 single-beat SRAM slave for the LSU/EXU load-store master.
// Word-addressed array behind independent read and write channel FSMs.
// Optional macro AXI_SRAM_RAND_DELAY_EN adds 0..3 random cycles of response
// latency (8-bit Fibonacci LFSR, taps 8,6,5,4) to stress master handshakes.
module ysyx_23060221_axi_sram_slave #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned WRITE_LAT = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int          IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  // Compare in 33 bits so a window ending at 4 GiB does not wrap.
  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [IW-1:0] to_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> 2;
    return IW'(off);
  endfunction

  logic [31:0] mem [DEPTH];

  // Extra latency cycles added when a channel enters its wait state.
  logic [7:0] extra;
`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  // Free-running LFSR, stepped every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign extra = {6'd0, lfsr[1:0]};
`else
  assign extra = 8'd0;
`endif

  // ---------------------------------------------------------------- write
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  wstate_t     w_state, w_state_n;
  logic        aw_got, w_got, aw_got_n, w_got_n;
  logic        awready_n, wready_n, bvalid_n;
  logic [1:0]  bresp_n;
  logic [3:0]  bid_n, aw_id;
  logic [IW-1:0] aw_idx;
  logic        aw_err, w_last_q;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [7:0]  w_cnt, w_cnt_n;
  logic        aw_fire, w_fire, aw_have, w_have, w_both, w_done, w_err;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign aw_have = aw_got | aw_fire;
  assign w_have  = w_got | w_fire;
  assign w_both  = aw_have & w_have;
  assign w_done  = (w_state == W_WAIT) && (w_cnt == 8'd0);
  assign w_err   = aw_err | ~w_last_q;

  // Write state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_n;
  end

  // Write next-state logic.
  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE:  if (w_both) w_state_n = W_WAIT;
      W_WAIT:  if (w_cnt == 8'd0) w_state_n = W_RESP;
      W_RESP:  if (bvalid && bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Write output logic: next values of the registered channel outputs.
  always_comb begin
    aw_got_n = 1'b0;
    w_got_n  = 1'b0;
    w_cnt_n  = w_cnt;
    bvalid_n = bvalid;
    bresp_n  = bresp;
    bid_n    = bid;
    case (w_state)
      W_IDLE: begin
        aw_got_n = aw_have & ~w_both;
        w_got_n  = w_have & ~w_both;
        if (w_both) w_cnt_n = 8'(WRITE_LAT - 1) + extra;
      end
      W_WAIT: begin
        if (w_cnt != 8'd0) w_cnt_n = w_cnt - 8'd1;
        else begin
          bvalid_n = 1'b1;
          bresp_n  = w_err ? 2'b10 : 2'b00;
          bid_n    = aw_id;
        end
      end
      W_RESP: if (bready) bvalid_n = 1'b0;
      default: ;
    endcase
    awready_n = (w_state_n == W_IDLE) & ~aw_got_n;
    wready_n  = (w_state_n == W_IDLE) & ~w_got_n;
  end

  // Write channel registers and AW/W capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      w_cnt    <= 8'd0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      bid      <= 4'd0;
      aw_id    <= 4'd0;
      aw_idx   <= '0;
      aw_err   <= 1'b0;
      w_data   <= 32'd0;
      w_strb   <= 4'd0;
      w_last_q <= 1'b0;
    end else begin
      awready <= awready_n;
      wready  <= wready_n;
      aw_got  <= aw_got_n;
      w_got   <= w_got_n;
      w_cnt   <= w_cnt_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      bid     <= bid_n;
      if (aw_fire) begin
        aw_id  <= awid;
        aw_idx <= to_idx(awaddr);
        aw_err <= ~in_range(awaddr) | (awlen != 8'd0) | (awburst != 2'd0) | (awsize > 3'd2);
      end
      if (w_fire) begin
        w_data   <= wdata;
        w_strb   <= wstrb;
        w_last_q <= wlast;
      end
    end
  end

  // Byte-lane commit at the end of the write wait; array is never reset.
  always_ff @(posedge clk) begin
    if (w_done && !w_err) begin
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
    end
  end

  // ----------------------------------------------------------------- read
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  rstate_t     r_state, r_state_n;
  logic        arready_n, rvalid_n, rlast_n;
  logic [1:0]  rresp_n;
  logic [3:0]  rid_n, ar_id;
  logic [31:0] rdata_n;
  logic [IW-1:0] ar_idx;
  logic        ar_err, ar_fire;
  logic [7:0]  r_cnt, r_cnt_n;

  assign ar_fire = arvalid & arready;

  // Read state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_n;
  end

  // Read next-state logic.
  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_n = R_WAIT;
      R_WAIT:  if (r_cnt == 8'd0) r_state_n = R_RESP;
      R_RESP:  if (rvalid && rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read output logic; the array read sees pre-commit contents (old data).
  always_comb begin
    r_cnt_n  = r_cnt;
    rvalid_n = rvalid;
    rlast_n  = rlast;
    rresp_n  = rresp;
    rid_n    = rid;
    rdata_n  = rdata;
    case (r_state)
      R_IDLE: if (ar_fire) r_cnt_n = 8'(READ_LAT - 1) + extra;
      R_WAIT: begin
        if (r_cnt != 8'd0) r_cnt_n = r_cnt - 8'd1;
        else begin
          rvalid_n = 1'b1;
          rlast_n  = 1'b1;
          rresp_n  = ar_err ? 2'b10 : 2'b00;
          rid_n    = ar_id;
          rdata_n  = ar_err ? 32'd0 : mem[ar_idx];
        end
      end
      R_RESP: if (rready) begin
        rvalid_n = 1'b0;
        rlast_n  = 1'b0;
      end
      default: ;
    endcase
    arready_n = (r_state_n == R_IDLE);
  end

  // Read channel registers and AR capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready <= 1'b0;
      r_cnt   <= 8'd0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= 2'b00;
      rid     <= 4'd0;
      rdata   <= 32'd0;
      ar_id   <= 4'd0;
      ar_idx  <= '0;
      ar_err  <= 1'b0;
    end else begin
      arready <= arready_n;
      r_cnt   <= r_cnt_n;
      rvalid  <= rvalid_n;
      rlast   <= rlast_n;
      rresp   <= rresp_n;
      rid     <= rid_n;
      rdata   <= rdata_n;
      if (ar_fire) begin
        ar_id  <= arid;
        ar_idx <= to_idx(araddr);
        ar_err <= ~in_range(araddr) | (arlen != 8'd0) | (arburst != 2'd0) | (arsize > 3'd2);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060221_axi_sram_slave.sv
// Directed bench for the AXI SRAM slave (READ_LAT=3, WRITE_LAT=2).
module tb_ysyx_23060221_axi_sram_slave;
  localparam int RL = 3;
  localparam int WL = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 1;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_cmp = 0, n_bad = 0;

  ysyx_23060221_axi_sram_slave #(.READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One write; W leads AW by w_lead cycles, bready held low b_hold cycles.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [3:0] id, input logic [7:0] len, input logic last,
                    input int w_lead, input int b_hold, input logic [1:0] exp_resp);
    logic aw_done, w_done, af, wf;
    int lat;
    awaddr = a; wdata = d; wstrb = s; awid = id; awlen = len; wlast = last;
    aw_done = 0; w_done = 0;
    awvalid = (w_lead == 0); wvalid = 1;
    for (int t = 0; t < 50 && !(aw_done && w_done); t++) begin
      af = awvalid && awready; wf = wvalid && wready;
      @(negedge clk);
      if (af) begin awvalid = 0; aw_done = 1; end
      if (wf) begin wvalid = 0; w_done = 1; end
      if (!aw_done && !awvalid && t + 1 >= w_lead) awvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    chk("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
    chk("wr_readys_low", {30'd0, awready, wready}, 32'd0);
    lat = 0;
    while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
    chk("wr_latency", lat, WL);
    chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
    chk("bid", {28'd0, bid}, {28'd0, id});
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
      chk("bid_hold", {28'd0, bid}, {28'd0, id});
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
    chk("awready_back", {30'd0, awready, wready}, 32'd3);
    awlen = 0; wlast = 1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic [2:0] sz,
                    input logic [31:0] exp_d, input logic [1:0] exp_resp);
    int t, lat;
    araddr = a; arid = id; arsize = sz; arvalid = 1;
    t = 0;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 0;
    chk("ar_handshake", {31'd0, arready}, 32'd0);
    lat = 0;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    chk("rd_latency", lat, RL);
    chk("rdata", rdata, exp_d);
    chk("rresp", {30'd0, rresp}, {30'd0, exp_resp});
    chk("rlast", {31'd0, rlast}, 32'd1);
    chk("rid", {28'd0, rid}, {28'd0, id});
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("rvalid_drop", {30'd0, rvalid, rlast}, 32'd0);
    chk("arready_back", {31'd0, arready}, 32'd1);
    arsize = 3'd2;
  endtask

  logic [31:0] model [4];
  logic [31:0] rv, mk;
  logic [3:0]  rs;
  int k, seen;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {25'd0, awready, wready, arready, bvalid, rvalid, rlast, |rdata},
        32'd0);
    rst = 0;
    chk("ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge", {29'd0, awready, wready, arready}, 32'd7);

    // Full word write and read back
    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h3, 8'd0, 1'b1, 0, 0, 2'b00);
    rd(32'h8000_0010, 4'h5, 3'd2, 32'hDEAD_BEEF, 2'b00);

    // Byte strobe merge
    wr(32'h8000_0020, 32'h1122_3344, 4'hF, 4'h1, 8'd0, 1'b1, 0, 0, 2'b00);
    wr(32'h8000_0020, 32'h00AB_0000, 4'b0100, 4'h2, 8'd0, 1'b1, 0, 0, 2'b00);
    rd(32'h8000_0020, 4'h6, 3'd2, 32'h11AB_3344, 2'b00);

    // W ahead of AW, stalled bready
    wr(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 4'hA, 8'd0, 1'b1, 3, 5, 2'b00);
    rd(32'h8000_0030, 4'h7, 3'd2, 32'hCAFE_F00D, 2'b00);

    // Address range edges and protocol errors
    wr(32'h8000_0000, 32'h0BAD_CAFE, 4'hF, 4'h0, 8'd0, 1'b1, 0, 0, 2'b00);
    wr(32'h8000_0FFC, 32'h5555_AAAA, 4'hF, 4'h0, 8'd0, 1'b1, 0, 0, 2'b00);
    rd(32'h8000_0FFC, 4'h1, 3'd2, 32'h5555_AAAA, 2'b00);
    rd(32'h7FFF_FFFC, 4'h2, 3'd2, 32'h0, 2'b10);
    wr(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 4'h9, 8'd0, 1'b1, 0, 0, 2'b10);
    rd(32'h8000_0000, 4'h3, 3'd2, 32'h0BAD_CAFE, 2'b00);
    wr(32'h8000_0000, 32'h1111_1111, 4'hF, 4'h4, 8'd1, 1'b1, 0, 0, 2'b10);
    wr(32'h8000_0000, 32'h2222_2222, 4'hF, 4'h4, 8'd0, 1'b0, 1, 0, 2'b10);
    rd(32'h8000_0000, 4'h3, 3'd3, 32'h0, 2'b10);
    rd(32'h8000_0000, 4'h3, 3'd2, 32'h0BAD_CAFE, 2'b00);

    // Reset pulse while a read is waiting: response must never appear
    araddr = 32'h8000_0010; arid = 4'hC; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_mid_read", {30'd0, rvalid, arready}, 32'd0);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    chk("no_rvalid_after_rst", seen, 0);
    chk("arready_after_rst", {31'd0, arready}, 32'd1);
    rd(32'h8000_0010, 4'h5, 3'd2, 32'hDEAD_BEEF, 2'b00);

    // Random traffic over four words against a model
    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom;
      wr(32'h8000_0100 + 32'(4 * i), model[i], 4'hF, 4'(i), 8'd0, 1'b1, 0, 0, 2'b00);
    end
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        rv = $urandom;
        rs = 4'($urandom_range(1, 15));
        mk = {{8{rs[3]}}, {8{rs[2]}}, {8{rs[1]}}, {8{rs[0]}}};
        model[k] = (model[k] & ~mk) | (rv & mk);
        wr(32'h8000_0100 + 32'(4 * k), rv, rs, 4'(i), 8'd0, 1'b1,
           $urandom_range(0, 2), $urandom_range(0, 2), 2'b00);
      end else begin
        rd(32'h8000_0100 + 32'(4 * k), 4'(i), 3'd2, model[k], 2'b00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
